// File: rtl/dmem_pkg.sv
// Shared encodings for the data-memory responder: RV32I load/store funct3 codes,
// FSM state constants and the funct3 legality check.
package dmem_pkg;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    // Stores have no unsigned variants, so BU/HU are legal only for loads.
    function automatic logic f3_legal(input logic we, input logic [2:0] f3);
        if (we) begin
            return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W);
        end
        return (f3 == F3_B) || (f3 == F3_H) || (f3 == F3_W) ||
               (f3 == F3_BU) || (f3 == F3_HU);
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane steering: store byte enables and replicated write data,
// load lane extraction with sign/zero extension, and the misalignment flag.
module dmem_lane_align
    import dmem_pkg::*;
(
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_raw_word,
    input  logic [31:0] i_st_data,
    output logic [3:0]  o_be,
    output logic [31:0] o_wdata_rep,
    output logic [31:0] o_ld_data,
    output logic        o_misalign
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        w_byte = i_raw_word[7:0];
        case (i_addr_lo)
            2'd1:    w_byte = i_raw_word[15:8];
            2'd2:    w_byte = i_raw_word[23:16];
            2'd3:    w_byte = i_raw_word[31:24];
            default: w_byte = i_raw_word[7:0];
        endcase
        w_half = i_addr_lo[1] ? i_raw_word[31:16] : i_raw_word[15:0];
    end

    always_comb begin
        o_be        = 4'b0000;
        o_wdata_rep = i_st_data;
        o_ld_data   = 32'h0;
        o_misalign  = 1'b0;
        case (i_funct3)
            F3_B, F3_BU: begin
                o_be        = 4'b0001 << i_addr_lo;
                o_wdata_rep = {4{i_st_data[7:0]}};
                o_ld_data   = {{24{w_byte[7] & ~i_funct3[2]}}, w_byte};
            end
            F3_H, F3_HU: begin
                o_be        = 4'b0011 << {i_addr_lo[1], 1'b0};
                o_wdata_rep = {2{i_st_data[15:0]}};
                o_ld_data   = {{16{w_half[15] & ~i_funct3[2]}}, w_half};
                o_misalign  = i_addr_lo[0];
            end
            F3_W: begin
                o_be        = 4'b1111;
                o_ld_data   = i_raw_word;
                o_misalign  = |i_addr_lo;
            end
            default: begin
                o_be = 4'b0000;
            end
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder with configurable wait states.
// Optional DMEM_PERF_CNT_EN adds load/store/error response counters.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int          DEPTH_WORDS = 1024,
    parameter int          WAIT_STATES = 1,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err
`ifdef DMEM_PERF_CNT_EN
    ,
    output logic [31:0] load_cnt,
    output logic [31:0] store_cnt,
    output logic [31:0] err_cnt
`endif
);

    localparam int          AW      = $clog2(DEPTH_WORDS);
    localparam logic [32:0] SPAN    = 33'(DEPTH_WORDS) * 33'd4;
    localparam logic [3:0]  WS_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    logic [1:0]  r_state;
    logic [3:0]  r_cnt;
    logic        r_we;
    logic [2:0]  r_funct3;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_word;
    logic [31:0] r_mem [DEPTH_WORDS];

    logic [31:0]   w_off;
    logic [31:0]   w_rd_addr;
    logic [AW-1:0] w_idx;
    logic [AW-1:0] w_rd_idx;
    logic          w_oor;
    logic          w_err;
    logic          w_resp;
    logic [3:0]    w_be;
    logic [31:0]   w_wdata_rep;
    logic [31:0]   w_ld_data;
    logic          w_misalign;

    // Below-base addresses wrap to huge offsets and fail the same range test.
    assign w_off     = r_addr - BASE_ADDR;
    assign w_oor     = ({1'b0, w_off} >= SPAN);
    assign w_idx     = AW'(w_off >> 2);
    // With zero wait states the read must be launched from the live request.
    assign w_rd_addr = (r_state == ST_IDLE) ? req_addr : r_addr;
    assign w_rd_idx  = AW'((w_rd_addr - BASE_ADDR) >> 2);
    assign w_resp    = (r_state == ST_RESP);
    assign w_err     = w_oor | w_misalign | ~f3_legal(r_we, r_funct3);

    dmem_lane_align u_lane_align (
        .i_funct3    (r_funct3),
        .i_addr_lo   (r_addr[1:0]),
        .i_raw_word  (r_word),
        .i_st_data   (r_wdata),
        .o_be        (w_be),
        .o_wdata_rep (w_wdata_rep),
        .o_ld_data   (w_ld_data),
        .o_misalign  (w_misalign)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= ST_IDLE;
            r_cnt    <= 4'd0;
            r_we     <= 1'b0;
            r_funct3 <= 3'd0;
            r_addr   <= 32'h0;
            r_wdata  <= 32'h0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (req_valid) begin
                        r_we     <= req_we;
                        r_funct3 <= req_funct3;
                        r_addr   <= req_addr;
                        r_wdata  <= req_wdata;
                        r_cnt    <= WS_INIT;
                        r_state  <= (WAIT_STATES > 0) ? ST_WAIT : ST_RESP;
                    end
                end
                ST_WAIT: begin
                    if (r_cnt == 4'd0) begin
                        r_state <= ST_RESP;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                ST_RESP: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Storage is deliberately not reset; a reset forces IDLE so no write fires.
    always_ff @(posedge clk) begin
        r_word <= r_mem[w_rd_idx];
        if (w_resp && r_we && !w_err) begin
            for (int i = 0; i < 4; i++) begin
                if (w_be[i]) begin
                    r_mem[w_idx][i*8 +: 8] <= w_wdata_rep[i*8 +: 8];
                end
            end
        end
    end

    assign req_ready = (r_state == ST_IDLE);
    assign rsp_valid = w_resp;
    assign rsp_err   = w_resp & w_err;
    assign rsp_rdata = (w_resp && !w_err && !r_we) ? w_ld_data : 32'h0;

`ifdef DMEM_PERF_CNT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            load_cnt  <= 32'h0;
            store_cnt <= 32'h0;
            err_cnt   <= 32'h0;
        end else if (w_resp) begin
            if (w_err) begin
                err_cnt <= err_cnt + 32'd1;
            end else if (r_we) begin
                store_cnt <= store_cnt + 32'd1;
            end else begin
                load_cnt <= load_cnt + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench: dut 0 (WAIT_STATES=1, base 0) and dut 1 (WAIT_STATES=0,
// 16 words at base 0x100) driven from a shared vector table.
module tb_dmem_responder;

    logic        clk;
    logic        rst_n;
    logic        req_valid  [2];
    logic        req_ready  [2];
    logic        req_we     [2];
    logic [2:0]  req_funct3 [2];
    logic [31:0] req_addr   [2];
    logic [31:0] req_wdata  [2];
    logic        rsp_valid  [2];
    logic [31:0] rsp_rdata  [2];
    logic        rsp_err    [2];
`ifdef DMEM_PERF_CNT_EN
    logic [31:0] load_cnt   [2];
    logic [31:0] store_cnt  [2];
    logic [31:0] err_cnt    [2];
`endif

    int n_chk;
    int n_fail;

    dmem_responder #(.DEPTH_WORDS(1024), .WAIT_STATES(1), .BASE_ADDR(32'h0000_0000)) dut0 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
        .req_funct3(req_funct3[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
        .rsp_valid(rsp_valid[0]), .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0])
`ifdef DMEM_PERF_CNT_EN
        , .load_cnt(load_cnt[0]), .store_cnt(store_cnt[0]), .err_cnt(err_cnt[0])
`endif
    );

    dmem_responder #(.DEPTH_WORDS(16), .WAIT_STATES(0), .BASE_ADDR(32'h0000_0100)) dut1 (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
        .req_funct3(req_funct3[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
        .rsp_valid(rsp_valid[1]), .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1])
`ifdef DMEM_PERF_CNT_EN
        , .load_cnt(load_cnt[1]), .store_cnt(store_cnt[1]), .err_cnt(err_cnt[1])
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct packed {
        logic        d;
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
        logic        exp_err;
    } vec_t;

    vec_t vec [29];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Starts on a falling edge; returns on the falling edge where rsp_valid is seen.
    task automatic xact(input int d, input logic we, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rd, output logic er, output int lat);
        int w;
        w = 0;
        while (!req_ready[d] && w < 20) begin
            @(negedge clk);
            w++;
        end
        req_valid[d]  = 1'b1;
        req_we[d]     = we;
        req_funct3[d] = f3;
        req_addr[d]   = addr;
        req_wdata[d]  = wdata;
        @(posedge clk);
        #1;
        req_valid[d]  = 1'b0;
        req_we[d]     = ~we;
        req_funct3[d] = ~f3;
        req_addr[d]   = $urandom;
        req_wdata[d]  = $urandom;
        lat = -1;
        rd  = 32'h0;
        er  = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (rsp_valid[d]) begin
                lat = c;
                rd  = rsp_rdata[d];
                er  = rsp_err[d];
                break;
            end
        end
        $display("xact dut%0d we=%0d f3=%0d addr=%h wdata=%h -> rdata=%h err=%0d lat=%0d",
                 d, we, f3, addr, wdata, rd, er, lat);
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        int          lat;
        int          exp_loads, exp_stores, exp_errs;

        n_chk = 0;
        n_fail = 0;
        for (int i = 0; i < 2; i++) begin
            req_valid[i] = 1'b0; req_we[i] = 1'b0; req_funct3[i] = 3'd0;
            req_addr[i] = 32'h0; req_wdata[i] = 32'h0;
        end

        //            d   we    f3      addr          wdata         exp_rd        err
        vec[0]  = '{1'b0, 1'b1, 3'd2, 32'h0000_0010, 32'hDEADBEEF, 32'h0000_0000, 1'b0};
        vec[1]  = '{1'b0, 1'b0, 3'd2, 32'h0000_0010, 32'h0,        32'hDEADBEEF, 1'b0};
        vec[2]  = '{1'b0, 1'b0, 3'd0, 32'h0000_0013, 32'h0,        32'hFFFFFFDE, 1'b0};
        vec[3]  = '{1'b0, 1'b0, 3'd4, 32'h0000_0013, 32'h0,        32'h000000DE, 1'b0};
        vec[4]  = '{1'b0, 1'b0, 3'd1, 32'h0000_0012, 32'h0,        32'hFFFFDEAD, 1'b0};
        vec[5]  = '{1'b0, 1'b0, 3'd5, 32'h0000_0010, 32'h0,        32'h0000BEEF, 1'b0};
        vec[6]  = '{1'b0, 1'b0, 3'd0, 32'h0000_0010, 32'h0,        32'hFFFFFFEF, 1'b0};
        vec[7]  = '{1'b0, 1'b1, 3'd0, 32'h0000_0011, 32'hA5A5A55A, 32'h0000_0000, 1'b0};
        vec[8]  = '{1'b0, 1'b0, 3'd2, 32'h0000_0010, 32'h0,        32'hDEAD5AEF, 1'b0};
        vec[9]  = '{1'b0, 1'b1, 3'd1, 32'h0000_0012, 32'h87651234, 32'h0000_0000, 1'b0};
        vec[10] = '{1'b0, 1'b0, 3'd2, 32'h0000_0010, 32'h0,        32'h12345AEF, 1'b0};
        vec[11] = '{1'b0, 1'b0, 3'd2, 32'h0000_0011, 32'h0,        32'h0000_0000, 1'b1};
        vec[12] = '{1'b0, 1'b1, 3'd1, 32'h0000_0013, 32'h0000FFFF, 32'h0000_0000, 1'b1};
        vec[13] = '{1'b0, 1'b0, 3'd2, 32'h0000_0010, 32'h0,        32'h12345AEF, 1'b0};
        vec[14] = '{1'b0, 1'b0, 3'd3, 32'h0000_0010, 32'h0,        32'h0000_0000, 1'b1};
        vec[15] = '{1'b0, 1'b1, 3'd4, 32'h0000_0010, 32'h0,        32'h0000_0000, 1'b1};
        vec[16] = '{1'b0, 1'b0, 3'd2, 32'h0000_1000, 32'h0,        32'h0000_0000, 1'b1};
        vec[17] = '{1'b0, 1'b1, 3'd2, 32'h0000_1010, 32'h0,        32'h0000_0000, 1'b1};
        vec[18] = '{1'b0, 1'b0, 3'd1, 32'h0000_0010, 32'h0,        32'h00005AEF, 1'b0};
        vec[19] = '{1'b0, 1'b0, 3'd4, 32'h0000_0011, 32'h0,        32'h0000005A, 1'b0};
        vec[20] = '{1'b1, 1'b1, 3'd2, 32'h0000_0104, 32'hCAFEF00D, 32'h0000_0000, 1'b0};
        vec[21] = '{1'b1, 1'b0, 3'd1, 32'h0000_0106, 32'h0,        32'hFFFFCAFE, 1'b0};
        vec[22] = '{1'b1, 1'b0, 3'd5, 32'h0000_0104, 32'h0,        32'h0000F00D, 1'b0};
        vec[23] = '{1'b1, 1'b1, 3'd2, 32'h0000_013C, 32'h01234567, 32'h0000_0000, 1'b0};
        vec[24] = '{1'b1, 1'b0, 3'd0, 32'h0000_013F, 32'h0,        32'h0000_0001, 1'b0};
        vec[25] = '{1'b1, 1'b0, 3'd2, 32'h0000_00FC, 32'h0,        32'h0000_0000, 1'b1};
        vec[26] = '{1'b1, 1'b1, 3'd2, 32'h0000_0140, 32'hFFFFFFFF, 32'h0000_0000, 1'b1};
        vec[27] = '{1'b1, 1'b0, 3'd2, 32'h0000_0104, 32'h0,        32'hCAFEF00D, 1'b0};
        vec[28] = '{1'b0, 1'b1, 3'd2, 32'h0000_0020, 32'h0000_0000, 32'h0000_0000, 1'b0};

        // Reset state, sampled while reset is still held
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset req_ready", 32'(req_ready[0]), 32'd1);
        check("reset rsp_valid", 32'(rsp_valid[0]), 32'd0);
        check("reset rsp_rdata", rsp_rdata[0], 32'h0);
        check("reset rsp_err", 32'(rsp_err[0]), 32'd0);
        check("reset req_ready dut1", 32'(req_ready[1]), 32'd1);
`ifdef DMEM_PERF_CNT_EN
        check("reset load_cnt", load_cnt[0], 32'h0);
        check("reset err_cnt", err_cnt[0], 32'h0);
`endif
        rst_n = 1'b1;
        @(negedge clk);

        exp_loads = 0; exp_stores = 0; exp_errs = 0;
        for (int i = 0; i < 29; i++) begin
            xact(int'(vec[i].d), vec[i].we, vec[i].f3, vec[i].addr, vec[i].wdata, rd, er, lat);
            check($sformatf("vec%0d rdata", i), rd, vec[i].exp_rd);
            check($sformatf("vec%0d err", i), 32'(er), 32'(vec[i].exp_err));
            check($sformatf("vec%0d latency", i), 32'(lat), (vec[i].d == 1'b0) ? 32'd2 : 32'd1);
            if (vec[i].d == 1'b0) begin
                if (vec[i].exp_err)  exp_errs++;
                else if (vec[i].we)  exp_stores++;
                else                 exp_loads++;
            end
        end
`ifdef DMEM_PERF_CNT_EN
        check("perf load_cnt", load_cnt[0], 32'(exp_loads));
        check("perf store_cnt", store_cnt[0], 32'(exp_stores));
        check("perf err_cnt", err_cnt[0], 32'(exp_errs));
`endif

        // Back-to-back with req_valid held: one accept every three cycles
        @(negedge clk);
        req_valid[0] = 1'b1; req_we[0] = 1'b0; req_funct3[0] = 3'd2; req_addr[0] = 32'h10;
        for (int c = 0; c < 9; c++) begin
            check($sformatf("held c%0d req_ready", c), 32'(req_ready[0]), 32'(c % 3 == 0));
            check($sformatf("held c%0d rsp_valid", c), 32'(rsp_valid[0]), 32'(c % 3 == 2));
            check($sformatf("held c%0d rsp_rdata", c), rsp_rdata[0],
                  (c % 3 == 2) ? 32'h12345AEF : 32'h0);
            @(negedge clk);
        end
        req_valid[0] = 1'b0;
        $display("held-valid sequence dut0 done");

        // Zero wait states: accept every other cycle
        req_valid[1] = 1'b1; req_we[1] = 1'b0; req_funct3[1] = 3'd2; req_addr[1] = 32'h104;
        for (int c = 0; c < 4; c++) begin
            check($sformatf("ws0 c%0d req_ready", c), 32'(req_ready[1]), 32'(c % 2 == 0));
            check($sformatf("ws0 c%0d rsp_valid", c), 32'(rsp_valid[1]), 32'(c % 2 == 1));
            @(negedge clk);
        end
        req_valid[1] = 1'b0;
        $display("held-valid sequence dut1 done");

        // Reset during WAIT drops the pending store and its response
        req_valid[0] = 1'b1; req_we[0] = 1'b1; req_funct3[0] = 3'd2;
        req_addr[0] = 32'h20; req_wdata[0] = 32'h11111111;
        @(posedge clk);
        #1 req_valid[0] = 1'b0;
        @(negedge clk);
        check("midrst wait req_ready", 32'(req_ready[0]), 32'd0);
        rst_n = 1'b0;
        #1;
        check("midrst async req_ready", 32'(req_ready[0]), 32'd1);
        #2 rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check($sformatf("midrst c%0d rsp_valid", c), 32'(rsp_valid[0]), 32'd0);
        end
        $display("mid-operation reset applied");
`ifdef DMEM_PERF_CNT_EN
        check("midrst store_cnt", store_cnt[0], 32'h0);
`endif
        xact(0, 1'b0, 3'd2, 32'h20, 32'h0, rd, er, lat);
        check("midrst LW rdata", rd, 32'h0);
        check("midrst LW err", 32'(er), 32'd0);
`ifdef DMEM_PERF_CNT_EN
        check("midrst load_cnt", load_cnt[0], 32'd1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
